ifetch_buffer: RTL
==================

// Module: ifetch_buffer
// PURPOSE
//   Consumer side of the PC: accepts fetch addresses from pc, reads instruction memory over a
//   req/ack handshake, and queues {pc, instruction} pairs for decode on valid/ready.
//   Sits between pc and decode; jump/branch redirects flush all fetched-but-unconsumed work.
// PARAMETERS
//   DEPTH   4   instruction queue entries (power of 2, >= 2)
//   AW      32  address/PC width
// PORTS
//   clk           in   1    rising-edge clock
//   rst           in   1    reset, asynchronous, active-high
//   pc_in         in   AW   fetch address from pc
//   pc_valid      in   1    pc_in is valid
//   pc_ready      out  1    address accepted this cycle; pc may advance
//   redirect      in   1    jump/branch taken: flush queue and in-flight fetch
//   imem_addr     out  AW   word-aligned read address {pc[AW-1:2],2'b00}
//   imem_req      out  1    read request, held until imem_ack
//   imem_ack      in   1    read complete; imem_rdata valid this cycle
//   imem_rdata    in   32   instruction word
//   inst_out      out  32   instruction at queue head
//   inst_pc       out  AW   PC of inst_out
//   inst_valid    out  1    queue not empty
//   inst_ready    in   1    decode pops head when inst_valid & inst_ready
// BEHAVIOUR
//   Reset: state IDLE; imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0, count=0,
//     pc_ready=0 while rst high. Asserting rst mid-request drops imem_req at once; the late
//     ack is ignored.
//   States: IDLE -> REQ on accept (pc_valid & pc_ready); REQ -> IDLE on imem_ack;
//     REQ -> DRAIN on redirect without ack; DRAIN -> IDLE on imem_ack (data discarded).
//     REQ with redirect and imem_ack in the same cycle -> IDLE, data discarded.
//   pc_ready = (state==IDLE) & (count < DEPTH) & ~redirect. Combinational, at most one
//     outstanding fetch.
//   Accept at edge N: imem_addr latched, imem_req=1 from cycle N+1. imem_addr is held stable
//     while imem_req is high.
//   imem_ack sampled at edge M in REQ: push {pc, imem_rdata}; inst_valid visible from M+1
//     (1-cycle min accept-to-ack gap). Minimum address-to-decode latency is 2 cycles.
//   Queue: circular, DEPTH entries, ptr wrap modulo DEPTH. Push and pop in the same cycle
//     leave count unchanged, including when the queue is full. The credit check stops
//     overflow. inst_out/inst_pc drive the head entry directly, with no bubble.
//   Redirect (one cycle, has priority): count=0, ptrs=0, inst_valid=0 next cycle. A same-cycle
//     push or pop is cancelled. The pc presents the new target after that cycle.
//   Back-pressure: inst_ready=0 holds the head stable. When full, pc_ready=0 until a pop.
// CONFIGURATION
//   IFETCH_STATS_EN defined: adds ports stat_fetched out 32 and stat_flushed out 32.
//     stat_fetched counts pushes. stat_flushed counts entries discarded by redirect, plus 1
//     for each discarded in-flight response. Both are 0 on rst and wrap at 2^32.
//   Not defined: no stat ports or counters; all other behaviour is identical.
// TESTING
//   1 rst 2 cycles, pc_in=0x00400000 valid, ack 1 cycle after req, rdata=0x20080005, ready=1
//     -> imem_addr=0x00400000; inst_valid 2 cyc after accept, inst_out=0x20080005,
//     inst_pc=0x00400000
//   2 stream 0x00400000..0x0040000C with inst_ready=0 -> 4 entries, then pc_ready=0; raise
//     inst_ready -> pops in order, pc_ready reasserts the cycle after the first pop
//   3 req outstanding (ack delayed 3 cyc), pulse redirect -> DRAIN, imem_req held, response
//     dropped, inst_valid=0, next accept uses pc_in=0x00400100
//   4 queue holding 3 entries with push+pop in the same cycle -> count stays 3, order
//     preserved across pointer wrap after 10 pushes
//   5 assert rst while imem_req=1 -> imem_req=0 immediately, inst_valid=0, ack in the next
//     cycle causes no push
//   6 IFETCH_STATS_EN: 5 fetches, redirect with 2 queued + 1 in flight -> stat_fetched=5,
//     stat_flushed=3

Source files
------------

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: takes fetch addresses from the pc, reads imem over req/ack and
// queues {pc, instruction} pairs for decode. Optional counters under IFETCH_STATS_EN.
module ifetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          redirect,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   inst_out,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]   stat_fetched,
  output logic [31:0]   stat_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] fetch_pc;
  logic [31:0]   q_inst [DEPTH];
  logic [AW-1:0] q_pc   [DEPTH];
  logic          accept, push, pop;

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // ready never depends on valid. Redirect cancels any same-cycle accept, push or pop.
  assign pc_ready   = ~rst & (state == IDLE) & (count < FULL) & ~redirect;
  assign accept     = pc_valid & pc_ready;
  assign push       = (state == REQ) & imem_ack & ~redirect;
  assign pop        = inst_valid & inst_ready & ~redirect;
  assign imem_req   = (state != IDLE);
  assign inst_valid = (count != '0);
  assign inst_out   = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DRAIN keeps imem_req up so the memory's pending response is absorbed and dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ: begin
        if (imem_ack)      state_nxt = IDLE;
        else if (redirect) state_nxt = DRAIN;
      end
      DRAIN:   if (imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr <= '0;
      fetch_pc  <= '0;
    end else if (accept) begin
      imem_addr <= {pc_in[AW-1:2], 2'b00};
      fetch_pc  <= pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (push) begin
      q_inst[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

`ifdef IFETCH_STATS_EN
  // A redirect in REQ always loses the outstanding response, even if it acks that cycle.
  logic inflight_lost;
  assign inflight_lost = (state == REQ) & redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (push)     stat_fetched <= stat_fetched + 32'd1;
      if (redirect) stat_flushed <= stat_flushed + 32'(count) + {31'd0, inflight_lost};
    end
  end
`endif

endmodule
